// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g} with a in bit 6; all patterns are active-low.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg_n
);

    assign seg_n = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered
// display data, leading-zero suppression and an anti-ghost blank at slot start.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done,
    output logic                    load_ack
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d, act_value_q, act_value_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    ack_stage_q, ack_stage_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_done_q, frame_done_d;
    seg_t                    seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;

    logic                  tc, boundary, xfer, zero_run;
    logic [3:0]            cur_nibble;
    logic                  cur_dp, cur_blank, cur_dark;
    logic [NUM_DIGITS-1:0] lz_dark;
    seg_t                  dec_seg_n;

    seg7_hex_decode u_dec (
        .nibble (cur_nibble),
        .seg_n  (dec_seg_n)
    );

    // Scan counters and buffer hand-over
    always_comb begin
        div_cnt_d    = div_cnt_q;
        digit_idx_d  = digit_idx_q;
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;

        tc       = enable && (div_cnt_q == DIV_LAST);
        boundary = tc && (digit_idx_q == IDX_LAST);
        // A stopped display has no frame to protect, so it takes new data at once.
        xfer     = pend_valid_q && (boundary || !enable);

        if (enable) begin
            if (tc) begin
                div_cnt_d   = '0;
                digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end

        if (xfer) begin
            act_value_d = pend_value_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
        end

        if (load) begin
            pend_value_d = value_in;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end else if (xfer) begin
            pend_valid_d = 1'b0;
        end

        frame_done_d = boundary;
        ack_stage_d  = xfer;
        load_ack_d   = ack_stage_q;
    end

    // Digit selection, suppression and output pattern
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_dark   = 1'b0;
        lz_dark    = '0;
        zero_run   = 1'b1;
        seg_n_d    = SEG_OFF;
        dp_n_d     = 1'b1;
        an_n_d     = '1;

        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (act_value_q[4*i +: 4] == 4'h0);
            lz_dark[i] = zero_run;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                cur_nibble = act_value_q[4*i +: 4];
                cur_dp     = act_dp_q[i];
                cur_blank  = act_blank_q[i];
                cur_dark   = lz_suppress && lz_dark[i];
                an_n_d[i]  = !(enable && (div_cnt_q >= BLANK_END));
            end
        end

        if (enable && (div_cnt_q >= BLANK_END) && !cur_blank) begin
            seg_n_d = cur_dark ? SEG_OFF : dec_seg_n;
            dp_n_d  = !cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            ack_stage_q  <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            ack_stage_q  <= ack_stage_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;

endmodule
